// File: rtl/stopwatch_core.sv
// stopwatch_core: edge-detected tick counting into a 4-digit BCD time value,
// with a start/pause/clear state machine and a lap (display hold) function.
module stopwatch_core #(
  parameter int TICKS_PER_COUNT = 1,
  parameter bit MODE_MMSS       = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       running,
  output logic       lap_held,
  output logic       max_reached
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Digit1 is the tens-of-seconds digit in MM:SS mode, hence the lower limit.
  localparam logic [3:0]  D1_MAX    = MODE_MMSS ? 4'd5 : 4'd9;
  localparam logic [15:0] LIMITS    = {4'd9, 4'd9, D1_MAX, 4'd9};
  localparam logic [15:0] MAX_VAL   = LIMITS;
  localparam logic [15:0] PRESC_TOP = 16'(TICKS_PER_COUNT - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic        lap_held_q, lap_held_d;
  logic        running_q, running_d;
  logic        max_reached_q, max_reached_d;

  logic tick_in_q, start_stop_q, clear_q, lap_q;
  logic tick_rise, ss_rise, clr_rise, lap_rise;

  logic [15:0] cnt_inc;
  logic [4:0]  carry;
  logic        count_step;

  // Input history for rising-edge detection; reset high so a level already
  // asserted when reset releases is not mistaken for a press or tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_in_q    <= 1'b1;
      start_stop_q <= 1'b1;
      clear_q      <= 1'b1;
      lap_q        <= 1'b1;
    end else begin
      tick_in_q    <= tick_in;
      start_stop_q <= start_stop;
      clear_q      <= clear;
      lap_q        <= lap;
    end
  end

  assign tick_rise = tick_in    & ~tick_in_q;
  assign ss_rise   = start_stop & ~start_stop_q;
  assign clr_rise  = clear      & ~clear_q;
  assign lap_rise  = lap        & ~lap_q;

  // BCD ripple increment: each digit wraps at its own limit and carries on.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
      logic at_limit;
      assign at_limit = (cnt_q[gi*4 +: 4] == LIMITS[gi*4 +: 4]);
      assign cnt_inc[gi*4 +: 4] = !carry[gi] ? cnt_q[gi*4 +: 4] :
                                  at_limit   ? 4'd0 :
                                               cnt_q[gi*4 +: 4] + 4'd1;
      assign carry[gi+1] = carry[gi] & at_limit;
    end
  endgenerate

  // A tick completes a count only when the prescaler is at its top value.
  assign count_step = tick_rise && (presc_q == PRESC_TOP);

  // Next-state, count, prescaler and lap-hold decisions.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    lap_held_d = lap_held_q;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        presc_d    = '0;
        lap_held_d = 1'b0;
        // clear beats start when both rise together
        if (!clr_rise && ss_rise) state_d = RUNNING;
      end
      RUNNING: begin
        if (clr_rise) begin
          state_d    = IDLE;
          cnt_d      = '0;
          presc_d    = '0;
          lap_held_d = 1'b0;
        end else begin
          if (tick_rise) begin
            if (count_step) begin
              presc_d = '0;
              cnt_d   = cnt_inc;
            end else begin
              presc_d = presc_q + 16'd1;
            end
          end
          if (count_step && (cnt_inc == MAX_VAL)) begin
            state_d    = DONE;
            lap_held_d = 1'b0;
          end else begin
            if (ss_rise)  state_d    = PAUSED;
            if (lap_rise) lap_held_d = ~lap_held_q;
          end
        end
      end
      PAUSED: begin
        if (clr_rise) begin
          state_d    = IDLE;
          cnt_d      = '0;
          presc_d    = '0;
          lap_held_d = 1'b0;
        end else begin
          if (ss_rise) state_d = RUNNING;
          // a paused lap press can only release a hold, never take one
          if (lap_rise && lap_held_q) lap_held_d = 1'b0;
        end
      end
      DONE: begin
        lap_held_d = 1'b0;
        if (clr_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        presc_d    = '0;
        lap_held_d = 1'b0;
      end
    endcase
  end

  // Display holds only while a hold persists; a new hold latches the
  // (possibly just incremented) live count, otherwise it tracks live.
  always_comb begin
    disp_d        = (lap_held_d && lap_held_q) ? disp_q : cnt_d;
    running_d     = (state_d == RUNNING);
    max_reached_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      cnt_q         <= '0;
      disp_q        <= '0;
      lap_held_q    <= 1'b0;
      running_q     <= 1'b0;
      max_reached_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      disp_q        <= disp_d;
      lap_held_q    <= lap_held_d;
      running_q     <= running_d;
      max_reached_q <= max_reached_d;
    end
  end

  assign digit3      = disp_q[15:12];
  assign digit2      = disp_q[11:8];
  assign digit1      = disp_q[7:4];
  assign digit0      = disp_q[3:0];
  assign running     = running_q;
  assign lap_held    = lap_held_q;
  assign max_reached = max_reached_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: three instances share the stimulus
// (1 tick/count MM:SS, 4 ticks/count MM:SS, 1 tick/count decimal).
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_in = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;

  logic [3:0] a_d3, a_d2, a_d1, a_d0;
  logic       a_run, a_lap, a_max;
  logic [3:0] b_d3, b_d2, b_d1, b_d0;
  logic       b_run, b_lap, b_max;
  logic [3:0] c_d3, c_d2, c_d1, c_d0;
  logic       c_run, c_lap, c_max;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.TICKS_PER_COUNT(1), .MODE_MMSS(1'b1)) u_a (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .digit3(a_d3), .digit2(a_d2), .digit1(a_d1), .digit0(a_d0),
    .running(a_run), .lap_held(a_lap), .max_reached(a_max)
  );

  stopwatch_core #(.TICKS_PER_COUNT(4), .MODE_MMSS(1'b1)) u_b (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .digit3(b_d3), .digit2(b_d2), .digit1(b_d1), .digit0(b_d0),
    .running(b_run), .lap_held(b_lap), .max_reached(b_max)
  );

  stopwatch_core #(.TICKS_PER_COUNT(1), .MODE_MMSS(1'b0)) u_c (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap),
    .digit3(c_d3), .digit2(c_d2), .digit1(c_d1), .digit0(c_d0),
    .running(c_run), .lap_held(c_lap), .max_reached(c_max)
  );

  wire [15:0] a_disp = {a_d3, a_d2, a_d1, a_d0};
  wire [15:0] b_disp = {b_d3, b_d2, b_d1, b_d0};
  wire [15:0] c_disp = {c_d3, c_d2, c_d1, c_d0};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Raise the selected inputs for one clock, then drop them; returns on a
  // negedge after the edge that sampled the high level.
  task automatic pulse(input bit s, input bit c, input bit l, input bit t);
    @(negedge clk);
    start_stop = s; clear = c; lap = l; tick_in = t;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; tick_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0; tick_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset with start_stop held through release: no start.
    start_stop = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_running", 32'(a_run), 32'd0);
    check_val("rst_digits", 32'(a_disp), 32'h0000);
    check_val("rst_lap_held", 32'(a_lap), 32'd0);
    check_val("rst_max", 32'(a_max), 32'd0);
    start_stop = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_release_no_start", 32'(a_run), 32'd0);

    // Minute rollover in MM:SS vs plain decimal.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("start_running", 32'(a_run), 32'd1);
    ticks(60);
    check_val("mmss_60", 32'(a_disp), 32'h0100);
    check_val("dec_60", 32'(c_disp), 32'h0060);
    ticks(9);
    check_val("mmss_69", 32'(a_disp), 32'h0109);
    check_val("dec_69", 32'(c_disp), 32'h0069);

    // Prescaler of 4 holds its phase through a pause.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    check_val("pre4_after7", 32'(b_disp), 32'h0001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre4_paused", 32'(b_run), 32'd0);
    ticks(5);
    check_val("pre4_frozen", 32'(b_disp), 32'h0001);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1);
    check_val("pre4_resume", 32'(b_disp), 32'h0002);
    check_val("pre1_same_run", 32'(a_disp), 32'h0008);

    // Lap hold and release.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(30);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("lap_set", 32'(a_lap), 32'd1);
    ticks(15);
    check_val("lap_hold_disp", 32'(a_disp), 32'h0030);
    check_val("lap_still_held", 32'(a_lap), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("lap_release_disp", 32'(a_disp), 32'h0045);
    check_val("lap_released", 32'(a_lap), 32'd0);

    // Run to the maximum and stop there.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5998);
    check_val("near_max", 32'(a_disp), 32'h9958);
    check_val("dec_5998", 32'(c_disp), 32'h5998);
    ticks(1);
    check_val("at_max", 32'(a_disp), 32'h9959);
    check_val("max_flag", 32'(a_max), 32'd1);
    check_val("max_not_running", 32'(a_run), 32'd0);
    ticks(3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("max_frozen", 32'(a_disp), 32'h9959);
    check_val("max_ignores_start", 32'(a_run), 32'd0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("max_clear_digits", 32'(a_disp), 32'h0000);
    check_val("max_clear_flag", 32'(a_max), 32'd0);
    ticks(1);
    check_val("idle_no_count", 32'(a_disp), 32'h0000);

    // Clear beats start; tick coincident with pause is counted.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(12);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("paused_12", 32'(a_disp), 32'h0012);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("clr_beats_start_digits", 32'(a_disp), 32'h0000);
    check_val("clr_beats_start_run", 32'(a_run), 32'd0);
    ticks(1);
    check_val("clr_stays_idle", 32'(a_disp), 32'h0000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5);
    check_val("run_5", 32'(a_disp), 32'h0005);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check_val("tick_with_pause_cnt", 32'(a_disp), 32'h0006);
    check_val("tick_with_pause_run", 32'(a_run), 32'd0);
    ticks(1);
    check_val("paused_frozen", 32'(a_disp), 32'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
